audio_adc_rx: RTL and testbench

//  Receives the WM8731 ADC serial stream once the codec has been configured over I2C
//  (master mode, 16-bit, MSB-first, left-justified). The codec drives BCLK, ADCLRC, ADCDAT.

---
 rtl/audio_adc_rx.sv | 160 ++++++++++++++++
 tb/tb_audio_adc_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// WM8731 left-justified ADC receiver: synchronises BCLK/ADCLRC/ADCDAT into clk and
// deserialises each LRC frame into a left/right sample pair on a valid/ready port.
module audio_adc_rx #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  aud_bclk,
  input  logic                  aud_adclrc,
  input  logic                  aud_adcdat,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {WAIT_SYNC, SHIFT_L, SHIFT_R} state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrc_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_bclk_prev;
  logic                   r_lrc_prev;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_bitcnt;
  logic [DATA_WIDTH-1:0]  r_sh_l;
  logic [DATA_WIDTH-1:0]  r_sh_r;
  logic [DATA_WIDTH-1:0]  r_hold_l;
  logic                   r_commit;

  logic w_bclk;
  logic w_lrc;
  logic w_dat;
  logic w_bit_rise;
  logic w_lrc_rise;
  logic w_lrc_fall;
  logic w_bit_take;

  assign w_bclk     = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrc      = r_lrc_sync[SYNC_STAGES-1];
  assign w_dat      = r_dat_sync[SYNC_STAGES-1];
  assign w_bit_rise = w_bclk & ~r_bclk_prev;
  assign w_lrc_rise = w_lrc & ~r_lrc_prev;
  assign w_lrc_fall = ~w_lrc & r_lrc_prev;
  assign w_bit_take = w_bit_rise && (r_bitcnt < FULL_CNT);

  // Input synchronisers and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_dat_sync  <= '0;
      r_bclk_prev <= 1'b0;
      r_lrc_prev  <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], aud_bclk};
      r_lrc_sync  <= {r_lrc_sync[SYNC_STAGES-2:0], aud_adclrc};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], aud_adcdat};
      r_bclk_prev <= w_bclk;
      r_lrc_prev  <= w_lrc;
    end
  end

  // Frame FSM; a bit arriving with the closing LRC edge opens the next channel as its MSB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= WAIT_SYNC;
      r_bitcnt  <= '0;
      r_sh_l    <= '0;
      r_sh_r    <= '0;
      r_hold_l  <= '0;
      r_commit  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      r_commit  <= 1'b0;
      if (!enable) begin
        r_state  <= WAIT_SYNC;
        r_bitcnt <= '0;
      end else begin
        case (r_state)
          WAIT_SYNC: begin
            if (w_lrc_rise) begin
              r_state  <= SHIFT_L;
              r_bitcnt <= w_bit_rise ? CNT_W'(1) : '0;
              r_sh_l   <= w_bit_rise ? DATA_WIDTH'(w_dat) : '0;
            end
          end
          SHIFT_L: begin
            if (w_lrc_fall) begin
              if (r_bitcnt == FULL_CNT) begin
                r_hold_l <= r_sh_l;
                r_state  <= SHIFT_R;
                r_bitcnt <= w_bit_rise ? CNT_W'(1) : '0;
                r_sh_r   <= w_bit_rise ? DATA_WIDTH'(w_dat) : '0;
              end else begin
                frame_err <= 1'b1;
                r_state   <= WAIT_SYNC;
                r_bitcnt  <= '0;
              end
            end else if (w_bit_take) begin
              r_sh_l   <= {r_sh_l[DATA_WIDTH-2:0], w_dat};
              r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
          end
          SHIFT_R: begin
            if (w_lrc_rise) begin
              if (r_bitcnt == FULL_CNT) begin
                r_commit <= 1'b1;
                r_state  <= SHIFT_L;
                r_bitcnt <= w_bit_rise ? CNT_W'(1) : '0;
                r_sh_l   <= w_bit_rise ? DATA_WIDTH'(w_dat) : '0;
              end else begin
                frame_err <= 1'b1;
                r_state   <= WAIT_SYNC;
                r_bitcnt  <= '0;
              end
            end else if (w_bit_take) begin
              r_sh_r   <= {r_sh_r[DATA_WIDTH-2:0], w_dat};
              r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
          end
          default: begin
            r_state  <= WAIT_SYNC;
            r_bitcnt <= '0;
          end
        endcase
      end
    end
  end

  // Output register and handshake; a pair committed onto an unaccepted pair is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (r_commit) begin
      if (!sample_valid || sample_ready) begin
        sample_left  <= r_hold_l;
        sample_right <= r_sh_r;
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: a behavioural WM8731 master drives BCLK/ADCLRC/ADCDAT.
module tb_audio_adc_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        aud_bclk = 1'b0;
  logic        aud_adclrc = 1'b0;
  logic        aud_adcdat = 1'b0;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overrun;
  logic        frame_err;

  int n_pass = 0;
  int n_total = 0;
  int ferr_cnt = 0;
  int vrise_cnt = 0;
  int ferr_base;
  logic valid_q = 1'b0;

  audio_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .aud_bclk(aud_bclk), .aud_adclrc(aud_adclrc), .aud_adcdat(aud_adcdat),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) ferr_cnt++;
    if (sample_valid && !valid_q) vrise_cnt++;
    valid_q <= sample_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One half-frame: LRC level set, MSB first, BCLK 5 clk low / 5 clk high, data changes on fall
  task automatic half(input logic lvl, input logic [15:0] d, input int nbits);
    aud_adclrc = lvl;
    for (int i = 0; i < nbits; i++) begin
      aud_adcdat = (i < 16) ? d[15-i] : 1'($urandom_range(0, 1));
      clks(5);
      aud_bclk = 1'b1;
      clks(5);
      aud_bclk = 1'b0;
    end
  endtask

  // Drop enable so any partial frame is discarded, idle the codec lines, re-enable
  task automatic resync();
    enable = 1'b0;
    aud_adclrc = 1'b0;
    aud_bclk = 1'b0;
    clks(6);
    enable = 1'b1;
    clks(2);
  endtask

  task automatic accept();
    sample_ready = 1'b1;
    clks(1);
    sample_ready = 1'b0;
    clks(1);
  endtask

  initial begin
    // 1: reset state, then codec runs with enable low
    clks(3);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_left", 32'(sample_left), 32'h0);
    check("rst_right", 32'(sample_right), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    clks(2);
    half(1'b1, 16'h1234, 16);
    half(1'b0, 16'h5678, 16);
    half(1'b1, 16'h0000, 16);
    check("dis_valid", 32'(sample_valid), 32'h0);
    check("dis_vrise", 32'(vrise_cnt), 32'h0);

    // 2: basic frame, valid held until ready
    resync();
    half(1'b1, 16'hA5C3, 16);
    half(1'b0, 16'h0F81, 16);
    half(1'b1, 16'h0000, 16);
    check("t2_valid", 32'(sample_valid), 32'h1);
    check("t2_left", 32'(sample_left), 32'h0000A5C3);
    check("t2_right", 32'(sample_right), 32'h00000F81);
    resync();
    check("t2_hold_valid", 32'(sample_valid), 32'h1);
    check("t2_hold_left", 32'(sample_left), 32'h0000A5C3);
    accept();
    check("t2_accept", 32'(sample_valid), 32'h0);

    // 3: 32 BCLKs per half-frame, trailing bits random
    ferr_base = ferr_cnt;
    half(1'b1, 16'hA5C3, 32);
    half(1'b0, 16'h0F81, 32);
    half(1'b1, 16'h0000, 32);
    check("t3_valid", 32'(sample_valid), 32'h1);
    check("t3_left", 32'(sample_left), 32'h0000A5C3);
    check("t3_right", 32'(sample_right), 32'h00000F81);
    check("t3_no_ferr", 32'(ferr_cnt - ferr_base), 32'h0);
    resync();
    accept();

    // 4: two frames with ready low -> first kept, overrun on the second
    half(1'b1, 16'h1111, 16);
    half(1'b0, 16'h2222, 16);
    half(1'b1, 16'h3333, 16);
    check("t4_first_valid", 32'(sample_valid), 32'h1);
    check("t4_no_overrun_yet", 32'(overrun), 32'h0);
    half(1'b0, 16'h4444, 16);
    half(1'b1, 16'h0000, 16);
    check("t4_overrun", 32'(overrun), 32'h1);
    check("t4_kept_left", 32'(sample_left), 32'h00001111);
    check("t4_kept_right", 32'(sample_right), 32'h00002222);
    resync();
    accept();
    check("t4_accept", 32'(sample_valid), 32'h0);
    check("t4_overrun_sticky", 32'(overrun), 32'h1);

    // 5: short left half-frame -> frame_err, then a clean frame
    ferr_base = ferr_cnt;
    half(1'b1, 16'hBEEF, 10);
    half(1'b0, 16'h1234, 16);
    check("t5_ferr", 32'(ferr_cnt - ferr_base), 32'h1);
    check("t5_no_valid", 32'(sample_valid), 32'h0);
    half(1'b1, 16'h7FFF, 16);
    check("t5_no_valid2", 32'(sample_valid), 32'h0);
    half(1'b0, 16'h8000, 16);
    half(1'b1, 16'h0000, 16);
    check("t5_valid", 32'(sample_valid), 32'h1);
    check("t5_left", 32'(sample_left), 32'h00007FFF);
    check("t5_right", 32'(sample_right), 32'h00008000);
    check("t5_ferr_once", 32'(ferr_cnt - ferr_base), 32'h1);
    resync();
    accept();

    // 6: reset mid left half, enable raised mid right half
    half(1'b1, 16'hAAAA, 8);
    reset = 1'b1;
    clks(1);
    reset = 1'b0;
    enable = 1'b0;
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    check("t6_rst_valid", 32'(sample_valid), 32'h0);
    half(1'b1, 16'hAAAA, 8);
    half(1'b0, 16'h5555, 8);
    enable = 1'b1;
    half(1'b0, 16'h5555, 8);
    half(1'b1, 16'hC0DE, 16);
    check("t6_no_partial", 32'(sample_valid), 32'h0);
    half(1'b0, 16'h0123, 16);
    half(1'b1, 16'h0000, 16);
    check("t6_valid", 32'(sample_valid), 32'h1);
    check("t6_left", 32'(sample_left), 32'h0000C0DE);
    check("t6_right", 32'(sample_right), 32'h00000123);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
